// File: rtl/rams_bank_arbiter.sv
// rams_bank_arbiter: shares NUM_RAMS single-port RAM banks between NUM_REQ
// requesters. Each bank has its own round-robin pointer, so requests to
// different banks are granted in the same cycle. A granted read returns its
// data on rsp_* one cycle later, taken from the bank's registered read port.
// Optional build macro RAMS_BANK_ARB_PERF_CNT_EN adds per-bank conflict
// counters (conflict_cnt) and a synchronous clear input (cnt_clr).
module rams_bank_arbiter #(
  parameter  int NUM_REQ  = 2,
  parameter  int NUM_RAMS = 2,
  parameter  int A_WID    = 10,
  parameter  int D_WID    = 32,
  localparam int B_WID    = (NUM_RAMS > 1) ? $clog2(NUM_RAMS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [NUM_REQ-1:0] req_we,
  input  logic [B_WID-1:0]   req_bank [NUM_REQ],
  input  logic [A_WID-1:0]   req_addr [NUM_REQ],
  input  logic [D_WID-1:0]   req_din  [NUM_REQ],
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic [D_WID-1:0]   rsp_data [NUM_REQ],
  output logic [NUM_RAMS-1:0] ram_ena,
  output logic [NUM_RAMS-1:0] ram_we,
  output logic [A_WID-1:0]   ram_addr [NUM_RAMS],
  output logic [D_WID-1:0]   ram_din  [NUM_RAMS],
  input  logic [D_WID-1:0]   ram_dout [NUM_RAMS]
`ifdef RAMS_BANK_ARB_PERF_CNT_EN
  ,
  output logic [15:0]        conflict_cnt [NUM_RAMS],
  input  logic               cnt_clr
`endif
);

  localparam int P_WID = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // round-robin pointers and read-response tracking
  logic [P_WID-1:0]   rr_ptr_q   [NUM_RAMS];
  logic [P_WID-1:0]   rr_ptr_d   [NUM_RAMS];
  logic [NUM_REQ-1:0] rsp_pend_q, rsp_pend_d;
  logic [B_WID-1:0]   rsp_bank_q [NUM_REQ];
  logic [B_WID-1:0]   rsp_bank_d [NUM_REQ];

  // arbitration intermediates
  logic [NUM_REQ-1:0] cand    [NUM_RAMS];
  logic [NUM_RAMS-1:0] gnt_vld;
  logic [NUM_RAMS-1:0] gnt_act;
  logic [P_WID-1:0]   gnt_idx [NUM_RAMS];
  logic [NUM_REQ-1:0] oor;

  // candidate matrix per bank, plus out-of-range requests that bypass arbitration
  always_comb begin
    for (int b = 0; b < NUM_RAMS; b++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        cand[b][r] = req_valid[r] && (int'(req_bank[r]) == b);
      end
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      oor[r] = req_valid[r] && (int'(req_bank[r]) >= NUM_RAMS);
    end
  end

  // per-bank round-robin pick: first candidate at or after the pointer, with wrap
  always_comb begin
    for (int b = 0; b < NUM_RAMS; b++) begin
      gnt_vld[b] = 1'b0;
      gnt_idx[b] = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
        if (!gnt_vld[b] && cand[b][(int'(rr_ptr_q[b]) + off) % NUM_REQ]) begin
          gnt_vld[b] = 1'b1;
          gnt_idx[b] = P_WID'((int'(rr_ptr_q[b]) + off) % NUM_REQ);
        end
      end
      // reset blocks every grant so nothing reaches the banks while rst is high
      gnt_act[b] = gnt_vld[b] && !rst;
    end
  end

  // ready: granted requesters plus out-of-range requests (accepted unopposed)
  always_comb begin
    req_ready = '0;
    for (int b = 0; b < NUM_RAMS; b++) begin
      if (gnt_act[b]) req_ready[gnt_idx[b]] = 1'b1;
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      if (oor[r] && !rst) req_ready[r] = 1'b1;
    end
  end

  // bank drive: route the granted requester, zero the idle banks
  always_comb begin
    for (int b = 0; b < NUM_RAMS; b++) begin
      ram_ena[b]  = gnt_act[b];
      ram_we[b]   = 1'b0;
      ram_addr[b] = '0;
      ram_din[b]  = '0;
      if (gnt_act[b]) begin
        ram_we[b]   = req_we[gnt_idx[b]];
        ram_addr[b] = req_addr[gnt_idx[b]];
        ram_din[b]  = req_din[gnt_idx[b]];
      end
    end
  end

  // next pointer: one past the winner; idle banks keep their pointer
  always_comb begin
    for (int b = 0; b < NUM_RAMS; b++) begin
      rr_ptr_d[b] = rr_ptr_q[b];
      if (gnt_act[b]) rr_ptr_d[b] = P_WID'((int'(gnt_idx[b]) + 1) % NUM_REQ);
    end
  end

  // response bookkeeping: an accepted read is pending for exactly one cycle
  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      rsp_pend_d[r] = req_ready[r] && !req_we[r];
      rsp_bank_d[r] = rsp_pend_d[r] ? req_bank[r] : rsp_bank_q[r];
    end
  end

  // response data: bank read port of the pending read; out-of-range reads give 0
  always_comb begin
    rsp_valid = rsp_pend_q;
    for (int r = 0; r < NUM_REQ; r++) begin
      rsp_data[r] = '0;
      if (rsp_pend_q[r] && (int'(rsp_bank_q[r]) < NUM_RAMS)) rsp_data[r] = ram_dout[rsp_bank_q[r]];
    end
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_pend_q <= '0;
      for (int b = 0; b < NUM_RAMS; b++) rr_ptr_q[b] <= '0;
      for (int r = 0; r < NUM_REQ; r++) rsp_bank_q[r] <= '0;
    end else begin
      rsp_pend_q <= rsp_pend_d;
      for (int b = 0; b < NUM_RAMS; b++) rr_ptr_q[b] <= rr_ptr_d[b];
      for (int r = 0; r < NUM_REQ; r++) rsp_bank_q[r] <= rsp_bank_d[r];
    end
  end

`ifdef RAMS_BANK_ARB_PERF_CNT_EN
  logic [15:0] cnt_q [NUM_RAMS];
  logic [15:0] cnt_d [NUM_RAMS];

  // conflict counters: clear wins, otherwise saturating count of contended cycles
  always_comb begin
    for (int b = 0; b < NUM_RAMS; b++) begin
      cnt_d[b] = cnt_q[b];
      if (cnt_clr) cnt_d[b] = '0;
      else if (($countones(cand[b]) >= 2) && (cnt_q[b] != 16'hFFFF)) cnt_d[b] = cnt_q[b] + 16'd1;
      conflict_cnt[b] = cnt_q[b];
    end
  end

  // counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_RAMS; b++) cnt_q[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_RAMS; b++) cnt_q[b] <= cnt_d[b];
    end
  end
`endif

endmodule

// File: tb/tb_rams_bank_arbiter.sv
// Bench for rams_bank_arbiter: directed scenarios followed by randomized
// traffic, all compared against a transaction-level model (grant picked by
// smallest round-robin distance, shadow memory for expected read data).
module tb_rams_bank_arbiter;
  localparam int NUM_REQ  = 2;
  localparam int NUM_RAMS = 2;
  localparam int A_WID    = 10;
  localparam int D_WID    = 32;
  localparam int B_WID    = 1;
  localparam int DEPTH    = 1 << A_WID;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_REQ-1:0] req_valid, req_ready, req_we, rsp_valid;
  logic [B_WID-1:0]   req_bank [NUM_REQ];
  logic [A_WID-1:0]   req_addr [NUM_REQ];
  logic [D_WID-1:0]   req_din  [NUM_REQ];
  logic [D_WID-1:0]   rsp_data [NUM_REQ];
  logic [NUM_RAMS-1:0] ram_ena, ram_we;
  logic [A_WID-1:0]   ram_addr [NUM_RAMS];
  logic [D_WID-1:0]   ram_din  [NUM_RAMS];
  logic [D_WID-1:0]   ram_dout [NUM_RAMS];
`ifdef RAMS_BANK_ARB_PERF_CNT_EN
  logic [15:0]        conflict_cnt [NUM_RAMS];
  logic               cnt_clr;
`endif

  rams_bank_arbiter #(.NUM_REQ(NUM_REQ), .NUM_RAMS(NUM_RAMS), .A_WID(A_WID), .D_WID(D_WID)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_bank(req_bank), .req_addr(req_addr), .req_din(req_din),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_ena(ram_ena), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
`ifdef RAMS_BANK_ARB_PERF_CNT_EN
    , .conflict_cnt(conflict_cnt), .cnt_clr(cnt_clr)
`endif
  );

  always #5 clk = ~clk;

  // RAM banks attached to the DUT: registered read, read-before-write
  logic [D_WID-1:0] mem [NUM_RAMS][DEPTH];
  always @(posedge clk) begin
    for (int b = 0; b < NUM_RAMS; b++) begin
      if (ram_ena[b]) begin
        ram_dout[b] <= mem[b][ram_addr[b]];
        if (ram_we[b]) mem[b][ram_addr[b]] <= ram_din[b];
      end
    end
  end

  // reference model state
  int               ptr   [NUM_RAMS];
  int               g     [NUM_RAMS];
  bit               er    [NUM_REQ];
  bit               ev    [NUM_REQ];
  logic [D_WID-1:0] ed    [NUM_REQ];
  int               waitc [NUM_REQ];
  logic [D_WID-1:0] shadow [NUM_RAMS][DEPTH];
`ifdef RAMS_BANK_ARB_PERF_CNT_EN
  int               mcnt  [NUM_RAMS];
`endif
  int ntest = 0, nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntest++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // expected grants: the candidate at the smallest forward distance from the pointer
  task automatic predict();
    for (int b = 0; b < NUM_RAMS; b++) begin
      int best;
      best = NUM_REQ;
      g[b] = -1;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (req_valid[r] && int'(req_bank[r]) == b) begin
          int d;
          d = (r - ptr[b] + NUM_REQ) % NUM_REQ;
          if (d < best) begin best = d; g[b] = r; end
        end
      end
    end
    for (int r = 0; r < NUM_REQ; r++)
      er[r] = !rst && req_valid[r] && (int'(req_bank[r]) >= NUM_RAMS);
    for (int b = 0; b < NUM_RAMS; b++)
      if (g[b] >= 0 && !rst) er[g[b]] = 1'b1;
  endtask

  task automatic model_reset();
    for (int b = 0; b < NUM_RAMS; b++) ptr[b] = 0;
    for (int r = 0; r < NUM_REQ; r++) begin ev[r] = 0; waitc[r] = 0; end
`ifdef RAMS_BANK_ARB_PERF_CNT_EN
    for (int b = 0; b < NUM_RAMS; b++) mcnt[b] = 0;
`endif
  endtask

  // mid-cycle: compare every output against the model
  task automatic to_neg();
    @(negedge clk);
    predict();
    for (int r = 0; r < NUM_REQ; r++) begin
      chk($sformatf("ready[%0d]", r), req_ready[r], er[r]);
      chk($sformatf("rsp_valid[%0d]", r), rsp_valid[r], ev[r]);
      if (ev[r]) chk($sformatf("rsp_data[%0d]", r), rsp_data[r], ed[r]);
      if (rst) chk($sformatf("rsp_data_rst[%0d]", r), rsp_data[r], 0);
      if (!rst && req_valid[r] && !req_ready[r]) begin
        waitc[r]++;
        chk($sformatf("fair_wait[%0d]", r), (waitc[r] <= NUM_REQ - 1), 1);
      end else waitc[r] = 0;
    end
    for (int b = 0; b < NUM_RAMS; b++) begin
      logic e, we;
      logic [A_WID-1:0] a;
      logic [D_WID-1:0] d;
      e = 0; we = 0; a = '0; d = '0;
      if (g[b] >= 0 && !rst) begin
        e = 1; we = req_we[g[b]]; a = req_addr[g[b]]; d = req_din[g[b]];
      end
      chk($sformatf("ram_ena[%0d]", b), ram_ena[b], e);
      chk($sformatf("ram_we[%0d]", b), ram_we[b], we);
      chk($sformatf("ram_addr[%0d]", b), ram_addr[b], a);
      chk($sformatf("ram_din[%0d]", b), ram_din[b], d);
`ifdef RAMS_BANK_ARB_PERF_CNT_EN
      chk($sformatf("conflict_cnt[%0d]", b), conflict_cnt[b], mcnt[b]);
`endif
    end
  endtask

  // clock edge: commit accepted transactions to the model
  task automatic to_pos();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      for (int r = 0; r < NUM_REQ; r++) begin
        ev[r] = er[r] && !req_we[r];
        if (ev[r]) ed[r] = (int'(req_bank[r]) < NUM_RAMS) ? shadow[req_bank[r]][req_addr[r]] : '0;
      end
      for (int r = 0; r < NUM_REQ; r++)
        if (er[r] && req_we[r] && int'(req_bank[r]) < NUM_RAMS) shadow[req_bank[r]][req_addr[r]] = req_din[r];
      for (int b = 0; b < NUM_RAMS; b++)
        if (g[b] >= 0) ptr[b] = (g[b] + 1) % NUM_REQ;
`ifdef RAMS_BANK_ARB_PERF_CNT_EN
      for (int b = 0; b < NUM_RAMS; b++) begin
        int n;
        n = 0;
        for (int r = 0; r < NUM_REQ; r++) if (req_valid[r] && int'(req_bank[r]) == b) n++;
        if (cnt_clr) mcnt[b] = 0;
        else if (n >= 2 && mcnt[b] < 16'hFFFF) mcnt[b]++;
      end
`endif
    end
    #1;
  endtask

  task automatic set_req(input int r, input bit v, input bit we, input int bank, input int addr, input logic [D_WID-1:0] din);
    req_valid[r] = v; req_we[r] = we;
    req_bank[r] = B_WID'(bank); req_addr[r] = A_WID'(addr); req_din[r] = din;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_we = '0;
    for (int r = 0; r < NUM_REQ; r++) begin req_bank[r] = '0; req_addr[r] = '0; req_din[r] = '0; end
    for (int b = 0; b < NUM_RAMS; b++) begin
      ram_dout[b] = '0;
      for (int a = 0; a < DEPTH; a++) begin mem[b][a] = '0; shadow[b][a] = '0; end
    end
`ifdef RAMS_BANK_ARB_PERF_CNT_EN
    cnt_clr = 1'b0;
`endif
    model_reset();
    @(posedge clk); #1;

    // reset holds everything off even with contending requests
    set_req(0, 1, 0, 0, 1, 0);
    set_req(1, 1, 0, 0, 2, 0);
    to_neg(); chk("rst_ready", req_ready, 0); chk("rst_ena", ram_ena, 0); chk("rst_rsp_valid", rsp_valid, 0);
    to_pos();
    rst = 1'b0;
    to_neg(); chk("first_gnt", req_ready, 2'b01); to_pos();
    set_req(0, 0, 0, 0, 0, 0);
    to_neg(); chk("second_gnt", req_ready, 2'b10); to_pos();
    set_req(1, 0, 0, 0, 0, 0);
    to_neg(); to_pos();

    // write then read back through another requester
    set_req(0, 1, 1, 0, 5, 32'hDEADBEEF);
    to_neg(); chk("wr_pulse", ram_we, 2'b01); to_pos();
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 1, 0, 0, 5, 0);
    to_neg(); chk("rd_ready", req_ready[1], 1); to_pos();
    set_req(1, 0, 0, 0, 0, 0);
    to_neg(); chk("rd_valid", rsp_valid[1], 1); chk("rd_data", rsp_data[1], 32'hDEADBEEF); to_pos();

    // sustained contention on bank 1 alternates 0,1,0,1
    set_req(0, 1, 0, 1, 3, 0);
    set_req(1, 1, 0, 1, 4, 0);
    for (int i = 0; i < 4; i++) begin
      to_neg(); chk($sformatf("alt%0d", i), req_ready, (i % 2) ? 2'b10 : 2'b01); to_pos();
    end
    set_req(0, 0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0, 0);
    to_neg(); to_pos();

    // different banks in the same cycle both proceed
    set_req(0, 1, 0, 0, 5, 0);
    set_req(1, 1, 0, 1, 3, 0);
    to_neg(); chk("par_ready", req_ready, 2'b11); chk("par_ena", ram_ena, 2'b11); to_pos();
    set_req(0, 0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0, 0);
    to_neg(); chk("par_rsp", rsp_valid, 2'b11); chk("par_d0", rsp_data[0], 32'hDEADBEEF); to_pos();

    // reset right after a read grant drops the response
    set_req(0, 1, 0, 0, 5, 0);
    to_neg(); to_pos();
    rst = 1'b1; model_reset();
    set_req(0, 0, 0, 0, 0, 0);
    to_neg(); chk("rst_drop", rsp_valid, 0); to_pos();
    rst = 1'b0;
    set_req(1, 1, 0, 0, 5, 0);
    to_neg(); to_pos();
    set_req(1, 0, 0, 0, 0, 0);
    to_neg(); chk("post_rst_d", rsp_data[1], 32'hDEADBEEF); to_pos();

    // random traffic with hold-until-ready and occasional async reset
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 149) == 0) begin rst = 1'b1; model_reset(); end
      else rst = 1'b0;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (!req_valid[r] || er[r])
          set_req(r, $urandom_range(0, 99) < 70, $urandom_range(0, 2) == 0,
                  $urandom_range(0, NUM_RAMS - 1), $urandom_range(0, 7), $urandom);
      end
      to_neg(); to_pos();
    end
    rst = 1'b0;
    set_req(0, 0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0, 0);
    to_neg(); to_pos();

`ifdef RAMS_BANK_ARB_PERF_CNT_EN
    cnt_clr = 1'b1; to_neg(); to_pos(); cnt_clr = 1'b0;
    set_req(0, 1, 0, 0, 1, 0); set_req(1, 1, 0, 0, 2, 0);
    for (int i = 0; i < 3; i++) begin
      to_neg(); to_pos();
      set_req(0, 1, 0, 0, 1, 0); set_req(1, 1, 0, 0, 2, 0);
    end
    set_req(0, 0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0, 0);
    to_neg(); chk("cnt3", conflict_cnt[0], 3); to_pos();
    cnt_clr = 1'b1; to_neg(); to_pos(); cnt_clr = 1'b0;
    to_neg(); chk("cnt_clr", conflict_cnt[0], 0); to_pos();
`endif

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
